// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned WORD_W    = BYTE_W * NUM_LANES;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// The read register doubles as the response data register, so it can be cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_en,
  input  logic                       i_we,
  input  logic                       i_clr,
  input  logic [$clog2(DEPTH)-1:0]   i_idx,
  input  logic [WORD_W-1:0]          i_wdata,
  input  logic [NUM_LANES-1:0]       i_wstrb,
  output logic [WORD_W-1:0]          o_rdata
);

  logic [NUM_LANES-1:0][BYTE_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0]                r_rdata;

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < int'(NUM_LANES); b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_idx][b] <= i_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= i_we ? '0 : WORD_W'(r_mem[i_idx]);
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding request/response data-memory slave with programmable wait latency,
// alignment/range checking and byte-strobed stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [NUM_LANES-1:0]  req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned HI_LSB = IDX_W + 2;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_access;

  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [WORD_W-1:0]    r_wdata;
  logic [NUM_LANES-1:0] r_wstrb;

  logic                 r_rsp_valid;
  logic                 r_rsp_err;

  logic                 w_accept;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_W-1:0]    w_wdata;
  logic [NUM_LANES-1:0] w_wstrb;
  logic                 w_err;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_arr_en;
  logic                 w_arr_clr;

  assign req_ready = (r_state == IDLE) && reset;
  assign w_accept  = req_ready && req_valid;

  // With zero latency the access happens on the accept edge, so use the live request.
  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;

  assign w_err = (|w_addr[1:0]) || (|w_addr[ADDR_W-1:HI_LSB]);
  assign w_idx = w_addr[2 +: IDX_W];

  assign w_arr_en  = w_access && reset && !w_err;
  assign w_arr_clr = w_access && reset && w_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY);
          end
        end
      end
      WAIT: begin
        // Last wait cycle performs the array access and enters RESP.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_arr_en),
    .i_we    (w_we),
    .i_clr   (w_arr_clr),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .o_rdata (rsp_rdata)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and a second at LATENCY=0 for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_wstrb;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_wstrb (z_req_wstrb),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the LATENCY=2 instance, with garbage driven after accept.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int t;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0004;
    req_wdata = ~wdata;
    req_wstrb = ~strb;
    t = 0;
    while (!rsp_valid && t < 20) begin
      tick();
      t++;
    end
    chk({tag, ".latency"}, 32'(t + 1), 32'd3);
    chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wstrb = '0;
    z_rsp_ready = 1'b1;

    tick();
    tick();
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err", 32'(rsp_err), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.release_ready", 32'(req_ready), 32'd1);

    txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
    txn("st10b", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    txn("ld10b", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEAA, 1'b0);

    txn("ld12", 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);
    txn("st00", 1'b1, 32'h0, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);
    txn("st400", 1'b1, 32'h400, 32'h5555_AAAA, 4'b1111, 32'h0, 1'b1);
    txn("ld00", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    txn("ldbig", 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'h0, 1'b1);

    txn("st20", 1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    txn("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    txn("ld20", 1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);

    // Backpressure: response must hold while stray requests are ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5 && !rsp_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0BAD_0BAD;
      req_wstrb = 4'hF;
      chk("hold.valid", 32'(rsp_valid), 32'd1);
      chk("hold.rdata", rsp_rdata, 32'hDEAD_BEAA);
      chk("hold.req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold.release", 32'(req_ready), 32'd1);
    txn("hold.ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEAA, 1'b0);

    // Reset one cycle into WAIT of a store: no commit, no response.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("wrst.valid", 32'(rsp_valid), 32'd0);
    chk("wrst.rdata", rsp_rdata, 32'd0);
    chk("wrst.err", 32'(rsp_err), 32'd0);
    chk("wrst.req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrst.no_rsp", 32'(rsp_valid), 32'd0);
    end
    txn("wrst.ld20", 1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);

    // Zero-latency instance: one transaction every two cycles.
    z_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_d;
      z_req_valid = 1'b1;
      z_req_we    = (k % 2 == 0);
      z_req_addr  = (k < 2) ? 32'h30 : 32'h34;
      z_req_wdata = (k < 2) ? 32'hA5A5_A5A5 : 32'h0BAD_CAFE;
      z_req_wstrb = 4'hF;
      exp_d = (k == 1) ? 32'hA5A5_A5A5 : ((k == 3) ? 32'h0BAD_CAFE : 32'h0);
      chk("z.ready", 32'(z_req_ready), 32'd1);
      tick();
      chk("z.valid", 32'(z_rsp_valid), 32'd1);
      chk("z.rdata", z_rsp_rdata, exp_d);
      chk("z.err", 32'(z_rsp_err), 32'd0);
      chk("z.busy", 32'(z_req_ready), 32'd0);
      tick();
      chk("z.valid_drop", 32'(z_rsp_valid), 32'd0);
    end
    z_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
